mips_mem_responder: RTL

//  Memory-side responder for the MIPS32 pipeline: serves the instruction-fetch channel (read-only)
//  and the load/store channel (read/write) from one single-ported word-addressed store.

---
 rtl/mips_mem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
// mips_mem_responder : single-port word store serving IF (read) and LW/SW
//   channels, data-priority arbitration with starvation guard, LAT-cycle
//   pipelined responses. Optional macro: MIPS_MEM_BOUNDS_EN (range checking).
// Revision: 1.0
// ============================================================================
module mips_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LAT     = 2,
  parameter int MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAXWAIT + 1);
  // Response tag layout: [34] valid, [33] data channel, [32] err, [31:0] data
  localparam int TW = 35;

  logic [31:0]   mem [DEPTH];

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          w_starve;
  logic          w_i_acc, w_d_acc;
  logic [31:0]   w_acc_addr;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_wr_en;
  logic [TW-1:0] w_tag;
  logic [TW-1:0] w_out_src;

  logic          i_rsp_valid_q, i_rsp_valid_d;
  logic [31:0]   i_rsp_data_q,  i_rsp_data_d;
  logic          d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]   d_rsp_data_q,  d_rsp_data_d;

  assign w_starve    = (wait_cnt_q == CW'(MAXWAIT));
  assign d_req_ready = !(w_starve && i_req_valid);
  assign i_req_ready = !d_req_valid || w_starve;
  assign w_d_acc     = d_req_valid && d_req_ready;
  assign w_i_acc     = i_req_valid && i_req_ready;

  assign w_acc_addr  = w_d_acc ? d_req_addr : i_req_addr;
  assign w_idx       = w_acc_addr[AW-1:0];

`ifdef MIPS_MEM_BOUNDS_EN
  assign w_oor = |w_acc_addr[31:AW];
`else
  assign w_oor = 1'b0;
`endif

  assign w_wr_en = w_d_acc && d_req_we && !w_oor;

  always_comb begin
    wait_cnt_d = '0;
    if (i_req_valid && !i_req_ready) begin
      wait_cnt_d = w_starve ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Storage is deliberately not reset so committed stores survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[w_idx] <= d_req_wdata;
    end
  end

  always_comb begin
    w_tag     = '0;
    w_tag[34] = w_d_acc || w_i_acc;
    w_tag[33] = w_d_acc;
    w_tag[32] = w_d_acc && w_oor;
    if (!((w_d_acc && d_req_we) || w_oor)) begin
      w_tag[31:0] = mem[w_idx];
    end
  end

  // LAT-1 tag stages followed by the output registers give exactly LAT cycles.
  generate
    if (LAT == 1) begin : g_lat_one
      assign w_out_src = w_tag;
    end else begin : g_lat_pipe
      localparam int PD = LAT - 1;
      logic [TW-1:0] pipe_q [PD];
      logic [TW-1:0] pipe_d [PD];

      always_comb begin
        pipe_d[0] = w_tag;
        for (int k = 1; k < PD; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PD; k++) begin
            pipe_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < PD; k++) begin
            pipe_q[k] <= pipe_d[k];
          end
        end
      end

      assign w_out_src = pipe_q[PD-1];
    end
  endgenerate

  always_comb begin
    i_rsp_valid_d = w_out_src[34] && !w_out_src[33];
    d_rsp_valid_d = w_out_src[34] &&  w_out_src[33];
    i_rsp_data_d  = i_rsp_valid_d ? w_out_src[31:0] : i_rsp_data_q;
    d_rsp_data_d  = d_rsp_valid_d ? w_out_src[31:0] : d_rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
    end else begin
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;

`ifdef MIPS_MEM_BOUNDS_EN
  logic d_rsp_err_q, d_rsp_err_d;

  assign d_rsp_err_d = d_rsp_valid_d ? w_out_src[32] : d_rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rsp_err_q <= 1'b0;
    end else begin
      d_rsp_err_q <= d_rsp_err_d;
    end
  end

  assign d_rsp_err = d_rsp_err_q;
`else
  // Upper address bits and the err tag bit are meaningless when wrapping.
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, w_acc_addr[31:AW], w_out_src[32]};
  assign d_rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire
